// File: rtl/tp_select_scanner_pkg.sv
// Shared constants for the TP select scanner: FSM encoding and default sizing.
package tp_select_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int DEF_DECISION_NUMS = 8;
  localparam int DEF_BIT_WIDTH_IDX = 3;
  localparam int FAIL_CNT_WIDTH    = 16;

  // Degenerate sizes collapse to a single test pattern.
  function automatic int eff_nums(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/tp_select_scanner_if.sv
// Indicator-in / selection-out handshake bundle for tp_select_scanner.
interface tp_select_scanner_if
  import tp_select_pkg::*;
#(
  parameter int DECISION_NUMS = DEF_DECISION_NUMS,
  parameter int BIT_WIDTH_IDX = DEF_BIT_WIDTH_IDX
);
  logic [DECISION_NUMS-1:0] in_indicTP;
  logic                     in_indicValid;
  logic                     out_inReady;
  logic [BIT_WIDTH_IDX-1:0] out_selIdx;
  logic                     out_selFail;
  logic                     out_selValid;
  logic                     in_selReady;

  modport slave (
    input  in_indicTP, in_indicValid, in_selReady,
    output out_inReady, out_selIdx, out_selFail, out_selValid
  );

  modport master (
    output in_indicTP, in_indicValid, in_selReady,
    input  out_inReady, out_selIdx, out_selFail, out_selValid
  );
endinterface

// File: rtl/tp_select_scanner_sat_cnt.sv
// Saturating up-counter with async active-low reset and synchronous clear.
module sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (srst) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/tp_select_scanner.sv
// Picks the lowest-index correctable test pattern by scanning one bit per enabled cycle.
// Optional fail counter output out_failCnt enabled by TP_SELECT_SCANNER_FAIL_CNT_EN.
module tp_select_scanner
  import tp_select_pkg::*;
#(
  parameter int DECISION_NUMS = DEF_DECISION_NUMS,
  parameter int BIT_WIDTH_IDX = DEF_BIT_WIDTH_IDX
) (
  input  logic                 clk,
  input  logic                 in_ctr_Arstn,
  input  logic                 in_ctr_Srst,
  input  logic                 in_ctr_en,
`ifdef TP_SELECT_SCANNER_FAIL_CNT_EN
  output logic [FAIL_CNT_WIDTH-1:0] out_failCnt,
`endif
  tp_select_scanner_if.slave   bus
);

  localparam int N_EFF = eff_nums(DECISION_NUMS);
  localparam logic [BIT_WIDTH_IDX-1:0] LAST_IDX = BIT_WIDTH_IDX'(N_EFF - 1);

  logic [1:0]               state_r, state_nxt_s;
  logic [BIT_WIDTH_IDX-1:0] ptr_r, ptr_nxt_s;
  logic [N_EFF-1:0]         vec_r, vec_nxt_s;
  logic [BIT_WIDTH_IDX-1:0] idx_r, idx_nxt_s;
  logic                     fail_r, fail_nxt_s;
  logic                     cur_bit_s;

  assign cur_bit_s = vec_r[ptr_r];

  // Next-state logic; with the enable low every register keeps its value.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    vec_nxt_s   = vec_r;
    idx_nxt_s   = idx_r;
    fail_nxt_s  = fail_r;
    if (in_ctr_en) begin
      case (state_r)
        IDLE: begin
          if (bus.in_indicValid) begin
            vec_nxt_s   = N_EFF'(bus.in_indicTP);
            ptr_nxt_s   = '0;
            state_nxt_s = SCAN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SCAN: begin
          if (cur_bit_s) begin
            idx_nxt_s   = ptr_r;
            fail_nxt_s  = 1'b0;
            state_nxt_s = HOLD;
          end else if (ptr_r == LAST_IDX) begin
            idx_nxt_s   = '0;
            fail_nxt_s  = 1'b1;
            state_nxt_s = HOLD;
          end else begin
            ptr_nxt_s   = ptr_r + BIT_WIDTH_IDX'(1);
          end
        end
        HOLD: begin
          if (bus.in_selReady) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and result registers; synchronous clear outranks the enable.
  always_ff @(posedge clk or negedge in_ctr_Arstn) begin
    if (!in_ctr_Arstn) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      vec_r   <= '0;
      idx_r   <= '0;
      fail_r  <= 1'b0;
    end else if (in_ctr_Srst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      vec_r   <= '0;
      idx_r   <= '0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      vec_r   <= vec_nxt_s;
      idx_r   <= idx_nxt_s;
      fail_r  <= fail_nxt_s;
    end
  end

  assign bus.out_inReady  = (state_r == IDLE);
  assign bus.out_selValid = (state_r == HOLD);
  assign bus.out_selIdx   = idx_r;
  assign bus.out_selFail  = fail_r;

`ifdef TP_SELECT_SCANNER_FAIL_CNT_EN
  logic fail_evt_s;

  assign fail_evt_s = in_ctr_en && (state_r == SCAN) && !cur_bit_s && (ptr_r == LAST_IDX);

  sat_cnt #(
    .WIDTH (FAIL_CNT_WIDTH)
  ) u_fail_cnt (
    .clk   (clk),
    .rst_n (in_ctr_Arstn),
    .srst  (in_ctr_Srst),
    .inc   (fail_evt_s),
    .cnt   (out_failCnt)
  );
`endif

endmodule

// File: tb/tb_tp_select_scanner.sv
// Directed table-driven bench for tp_select_scanner (DECISION_NUMS=8).
module tb_tp_select_scanner;

  logic clk = 1'b0;
  logic in_ctr_Arstn;
  logic in_ctr_Srst;
  logic in_ctr_en;
`ifdef TP_SELECT_SCANNER_FAIL_CNT_EN
  logic [15:0] out_failCnt;
  int exp_fails = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  tp_select_scanner_if #(.DECISION_NUMS(8), .BIT_WIDTH_IDX(3)) bus ();

  tp_select_scanner #(.DECISION_NUMS(8), .BIT_WIDTH_IDX(3)) dut (
    .clk          (clk),
    .in_ctr_Arstn (in_ctr_Arstn),
    .in_ctr_Srst  (in_ctr_Srst),
    .in_ctr_en    (in_ctr_en),
`ifdef TP_SELECT_SCANNER_FAIL_CNT_EN
    .out_failCnt  (out_failCnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vec;
    logic [2:0] idx;
    logic       fail;
    int         lat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one edge (the accept edge), then drop valid.
  task automatic accept(input logic [7:0] v);
    bus.in_indicTP    = v;
    bus.in_indicValid = 1'b1;
    tick();
    bus.in_indicValid = 1'b0;
    chk("accepted_ready_low", 32'(bus.out_inReady), 32'd0);
  endtask

  // Count edges after the accept edge until the result is valid.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_selValid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string name, input vec_t e, input int n);
    chk({name, "_lat"},   32'(n),                e.lat);
    chk({name, "_valid"}, 32'(bus.out_selValid), 32'd1);
    chk({name, "_idx"},   32'(bus.out_selIdx),   32'(e.idx));
    chk({name, "_fail"},  32'(bus.out_selFail),  32'(e.fail));
  endtask

  initial begin
    int n;
    vec_t e;
    tbl[0] = '{8'b0000_0001, 3'd0, 1'b0, 1};
    tbl[1] = '{8'b1010_0000, 3'd5, 1'b0, 6};
    tbl[2] = '{8'h00,        3'd0, 1'b1, 8};
    tbl[3] = '{8'h80,        3'd7, 1'b0, 8};
    tbl[4] = '{8'hFF,        3'd0, 1'b0, 1};
    tbl[5] = '{8'h0C,        3'd2, 1'b0, 3};
    tbl[6] = '{8'h40,        3'd6, 1'b0, 7};

    in_ctr_Arstn      = 1'b0;
    in_ctr_Srst       = 1'b0;
    in_ctr_en         = 1'b1;
    bus.in_indicTP    = 8'h00;
    bus.in_indicValid = 1'b1;
    bus.in_selReady   = 1'b1;
    #12;
    chk("rst_ready", 32'(bus.out_inReady),  32'd1);
    chk("rst_valid", 32'(bus.out_selValid), 32'd0);
    chk("rst_idx",   32'(bus.out_selIdx),   32'd0);
    chk("rst_fail",  32'(bus.out_selFail),  32'd0);
    bus.in_indicValid = 1'b0;
    in_ctr_Arstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].vec);
      wait_valid(n);
      check_result($sformatf("vec%0d", i), tbl[i], n);
`ifdef TP_SELECT_SCANNER_FAIL_CNT_EN
      if (tbl[i].fail) exp_fails++;
      chk($sformatf("vec%0d_failcnt", i), 32'(out_failCnt), 32'(exp_fails));
`endif
      tick();
      chk($sformatf("vec%0d_back_idle", i), 32'(bus.out_inReady), 32'd1);
      chk($sformatf("vec%0d_valid_drop", i), 32'(bus.out_selValid), 32'd0);
    end

    // HOLD with consumer stalled while a new vector is offered.
    bus.in_selReady = 1'b0;
    accept(8'h10);
    wait_valid(n);
    e = '{8'h10, 3'd4, 1'b0, 5};
    check_result("hold", e, n);
    bus.in_indicTP    = 8'hFF;
    bus.in_indicValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_selValid), 32'd1);
      chk("hold_idx",   32'(bus.out_selIdx),   32'd4);
      chk("hold_ready", 32'(bus.out_inReady),  32'd0);
    end
    bus.in_selReady = 1'b1;
    tick();
    chk("hold_release_ready", 32'(bus.out_inReady), 32'd1);
    tick();
    bus.in_indicValid = 1'b0;
    chk("hold_new_accept", 32'(bus.out_inReady), 32'd0);
    wait_valid(n);
    e = '{8'hFF, 3'd0, 1'b0, 1};
    check_result("hold_next", e, n);
    tick();

    // Async reset in the middle of a scan.
    accept(8'h80);
    tick();
    tick();
    tick();
    #1 in_ctr_Arstn = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.out_inReady),  32'd1);
    chk("arst_valid", 32'(bus.out_selValid), 32'd0);
    #2 in_ctr_Arstn = 1'b1;
    tick();
    chk("arst_after_valid", 32'(bus.out_selValid), 32'd0);
    accept(8'h04);
    wait_valid(n);
    e = '{8'h04, 3'd2, 1'b0, 3};
    check_result("arst_next", e, n);
    tick();

    // Enable toggling every cycle during the scan doubles latency.
    accept(8'h10);
    in_ctr_en = 1'b0;
    n = 0;
    while (bus.out_selValid !== 1'b1 && n < 40) begin
      tick();
      n++;
      in_ctr_en = ~in_ctr_en;
    end
    in_ctr_en = 1'b1;
    e = '{8'h10, 3'd4, 1'b0, 10};
    check_result("en_toggle", e, n);
    in_ctr_en = 1'b0;
    tick();
    chk("en_frozen_valid", 32'(bus.out_selValid), 32'd1);
    in_ctr_en = 1'b1;
    tick();
    chk("en_handshake", 32'(bus.out_inReady), 32'd1);

    // Synchronous clear while holding a result, with enable low.
    bus.in_selReady = 1'b0;
    accept(8'h40);
    wait_valid(n);
    e = '{8'h40, 3'd6, 1'b0, 7};
    check_result("srst_pre", e, n);
    in_ctr_en   = 1'b0;
    in_ctr_Srst = 1'b1;
    tick();
    in_ctr_Srst = 1'b0;
    in_ctr_en   = 1'b1;
    chk("srst_ready", 32'(bus.out_inReady),  32'd1);
    chk("srst_valid", 32'(bus.out_selValid), 32'd0);
    chk("srst_idx",   32'(bus.out_selIdx),   32'd0);
`ifdef TP_SELECT_SCANNER_FAIL_CNT_EN
    chk("srst_failcnt", 32'(out_failCnt), 32'd0);
`endif
    bus.in_selReady = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
